// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the parametrised video timing generator.
// The defaults describe 640x480@60 with a 2:1 pixel clock divide.
// Optional colour-bar test pattern: define VGA_TIMING_PAT_EN.
package vga_timing_pkg;

  localparam int DEF_CW         = 12;
  localparam int DEF_PIX_DIV    = 2;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_H_SYNC_POL = 0;
  localparam int DEF_V_SYNC_POL = 0;

  // Full period of one axis: active + front porch + sync + back porch.
  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // 4:4:4 colour of each of the eight vertical test bars, left to right.
  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd0:    rgb = 12'hFFF;  // white
      3'd1:    rgb = 12'hFF0;  // yellow
      3'd2:    rgb = 12'h0FF;  // cyan
      3'd3:    rgb = 12'h0F0;  // green
      3'd4:    rgb = 12'hF0F;  // magenta
      3'd5:    rgb = 12'hF00;  // red
      3'd6:    rgb = 12'h00F;  // blue
      3'd7:    rgb = 12'h000;  // black
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one video axis. Advances on inc and returns
// to zero after TOTAL-1; wrap is high on the inc that performs that return,
// so the horizontal instance can drive the vertical instance's inc.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int TOTAL = 800
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST_C = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Flag the step that leaves the last position of the axis.
  always_comb begin
    wrap = 1'b0;
    if (inc && (cnt_r == LAST_C)) begin
      wrap = 1'b1;
    end else begin
      wrap = 1'b0;
    end
  end

  // Position register: step on inc, fold back to zero past the last position.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc) begin
      if (cnt_r == LAST_C) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + ONE_C;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator. A pixel divider produces ticks; on each
// tick the h/v counters advance and every output register loads the decode of
// the pre-advance (h,v), so all outputs trail the counters by one tick and are
// aligned with each other. en_i low freezes everything; strobes fall to 0.
// Optional colour-bar test pattern on rgb_o: define VGA_TIMING_PAT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW         = DEF_CW,
  parameter int PIX_DIV    = DEF_PIX_DIV,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int H_SYNC_POL = DEF_H_SYNC_POL,
  parameter int V_SYNC_POL = DEF_V_SYNC_POL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          video_on,
  output logic          line_start_o,
  output logic          frame_start_o
`ifdef VGA_TIMING_PAT_EN
  ,
  output logic [11:0]   rgb_o
`endif
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST_C  = DW'(PIX_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE_C   = DW'(1);
  localparam logic [CW-1:0] H_ACT_C     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_LO_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_HI_C = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_LO_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_HI_C = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          H_POL_C     = (H_SYNC_POL != 0);
  localparam logic          V_POL_C     = (V_SYNC_POL != 0);

  // Reject modes that cannot be represented or make no sense.
  if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_err_total
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CW");
  end
  if (PIX_DIV < 1) begin : g_err_div
    $error("vga_timing_gen: PIX_DIV must be at least 1");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_region
    $error("vga_timing_gen: every region width must be non-zero");
  end

  logic [DW-1:0] div_r;
  logic          tick_s;
  logic [CW-1:0] h_s;
  logic [CW-1:0] v_s;
  logic          h_wrap_s;
  logic          unused_v_wrap_s;
  logic          vis_s;
  logic          hsync_s;
  logic          vsync_s;
  logic          h_zero_s;
  logic          v_zero_s;

  logic [CW-1:0] x_r;
  logic [CW-1:0] y_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          video_on_r;
  logic          line_start_r;
  logic          frame_start_r;

  // Pixel tick on the enabled clock where the divider sits at zero.
  always_comb begin
    tick_s = 1'b0;
    if (en_i && (div_r == {DW{1'b0}})) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Pixel divider: cycles 0..PIX_DIV-1 only while enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_r <= {DW{1'b0}};
    end else if (en_i) begin
      if (div_r == DIV_LAST_C) begin
        div_r <= {DW{1'b0}};
      end else begin
        div_r <= div_r + DIV_ONE_C;
      end
    end else begin
      div_r <= div_r;
    end
  end

  vga_axis_counter #(.CW(CW), .TOTAL(H_TOTAL)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (tick_s),
    .cnt   (h_s),
    .wrap  (h_wrap_s)
  );

  vga_axis_counter #(.CW(CW), .TOTAL(V_TOTAL)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (h_wrap_s),
    .cnt   (v_s),
    .wrap  (unused_v_wrap_s)
  );

  // Region decode of the current counter position.
  always_comb begin
    vis_s    = 1'b0;
    hsync_s  = ~H_POL_C;
    vsync_s  = ~V_POL_C;
    h_zero_s = (h_s == {CW{1'b0}});
    v_zero_s = (v_s == {CW{1'b0}});
    if ((h_s < H_ACT_C) && (v_s < V_ACT_C)) begin
      vis_s = 1'b1;
    end else begin
      vis_s = 1'b0;
    end
    if ((h_s >= H_SYNC_LO_C) && (h_s <= H_SYNC_HI_C)) begin
      hsync_s = H_POL_C;
    end else begin
      hsync_s = ~H_POL_C;
    end
    if ((v_s >= V_SYNC_LO_C) && (v_s <= V_SYNC_HI_C)) begin
      vsync_s = V_POL_C;
    end else begin
      vsync_s = ~V_POL_C;
    end
  end

  // Output registers: load on tick, hold otherwise; strobes last one clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_r           <= {CW{1'b0}};
      y_r           <= {CW{1'b0}};
      video_on_r    <= 1'b0;
      hsync_r       <= ~H_POL_C;
      vsync_r       <= ~V_POL_C;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (tick_s) begin
      x_r           <= h_s;
      y_r           <= v_s;
      video_on_r    <= vis_s;
      hsync_r       <= hsync_s;
      vsync_r       <= vsync_s;
      line_start_r  <= h_zero_s;
      frame_start_r <= h_zero_s && v_zero_s;
    end else begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign x_o           = x_r;
  assign y_o           = y_r;
  assign video_on      = video_on_r;
  assign hsync         = hsync_r;
  assign vsync         = vsync_r;
  assign line_start_o  = line_start_r;
  assign frame_start_o = frame_start_r;

`ifdef VGA_TIMING_PAT_EN
  // The incremental bar step needs at most one carry per pixel.
  if (H_ACTIVE < 8) begin : g_err_pat
    $error("vga_timing_gen: test pattern needs H_ACTIVE >= 8");
  end

  localparam int            AW           = CW + 4;
  localparam logic [AW-1:0] ACC_STEP_C   = AW'(8);
  localparam logic [AW-1:0] ACC_MOD_C    = AW'(H_ACTIVE);
  localparam logic [CW-1:0] H_ACT_LAST_C = CW'(H_ACTIVE - 1);

  logic [AW-1:0] acc_r;
  logic [AW-1:0] acc_sum_s;
  logic [2:0]    bar_r;
  logic [11:0]   rgb_r;

  // acc_r holds (h*8) mod H_ACTIVE; bar_r holds floor(h*8/H_ACTIVE).
  always_comb begin
    acc_sum_s = acc_r + ACC_STEP_C;
  end

  // Bar tracker follows h: cleared when h returns to 0, frozen past active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r <= {AW{1'b0}};
      bar_r <= 3'd0;
    end else if (tick_s) begin
      if (h_wrap_s) begin
        acc_r <= {AW{1'b0}};
        bar_r <= 3'd0;
      end else if (h_s < H_ACT_LAST_C) begin
        if (acc_sum_s >= ACC_MOD_C) begin
          acc_r <= acc_sum_s - ACC_MOD_C;
          bar_r <= bar_r + 3'd1;
        end else begin
          acc_r <= acc_sum_s;
          bar_r <= bar_r;
        end
      end else begin
        acc_r <= acc_r;
        bar_r <= bar_r;
      end
    end else begin
      acc_r <= acc_r;
      bar_r <= bar_r;
    end
  end

  // Pattern colour, loaded alongside video_on and blanked outside active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_r <= 12'h000;
    end else if (tick_s) begin
      if (vis_s) begin
        rgb_r <= bar_rgb(bar_r);
      end else begin
        rgb_r <= 12'h000;
      end
    end else begin
      rgb_r <= rgb_r;
    end
  end

  assign rgb_o = rgb_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a small 14x8 mode with PIX_DIV=2.
// The driver pushes the expected outputs for every clock into a queue, taken
// from a reference that derives (h,v) from the count of enabled clocks since
// reset; a separate monitor pops and compares just after each rising edge.
module tb_vga_timing_gen;

  localparam int CW = 5;
  localparam int PIX_DIV = 2;
  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 1;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int HPOL = 0, VPOL = 0;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en_i = 1'b0;
  logic          hsync, vsync, video_on, line_start_o, frame_start_o;
  logic [CW-1:0] x_o, y_o;
  logic [11:0]   rgb_dut;

  typedef struct {
    int            tag;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs, vs, von, ls, fs;
    logic [11:0]   rgb;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   m_e = 0;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] bar_tbl [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  vga_timing_gen #(
    .CW(CW), .PIX_DIV(PIX_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL)
  ) dut (
    .clk(clk), .reset(reset), .en_i(en_i),
    .hsync(hsync), .vsync(vsync), .x_o(x_o), .y_o(y_o),
    .video_on(video_on), .line_start_o(line_start_o),
    .frame_start_o(frame_start_o)
`ifdef VGA_TIMING_PAT_EN
    , .rgb_o(rgb_dut)
`endif
  );

`ifndef VGA_TIMING_PAT_EN
  assign rgb_dut = 12'h000;
`endif

  always #5 clk = ~clk;

  // Reference: the n-th enabled clock after reset is a tick iff n % PIX_DIV
  // == 0, showing pixel p = n / PIX_DIV, i.e. h = p % HT, v = (p / HT) % VT.
  task automatic model_step(input logic rst_v, input logic en_v);
    int p, h, v;
    if (!rst_v) begin
      m_e = 0;
      m.x = '0; m.y = '0; m.von = 1'b0; m.ls = 1'b0; m.fs = 1'b0;
      m.hs = (HPOL == 0); m.vs = (VPOL == 0); m.rgb = 12'h000;
    end else if (en_v) begin
      if (m_e % PIX_DIV == 0) begin
        p = m_e / PIX_DIV;
        h = p % HT;
        v = (p / HT) % VT;
        m.x   = CW'(h);
        m.y   = CW'(v);
        m.von = (h < H_ACTIVE) && (v < V_ACTIVE);
        m.hs  = ((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC)) == (HPOL != 0);
        m.vs  = ((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC)) == (VPOL != 0);
        m.ls  = (h == 0);
        m.fs  = (h == 0) && (v == 0);
`ifdef VGA_TIMING_PAT_EN
        m.rgb = m.von ? bar_tbl[(h * 8) / H_ACTIVE] : 12'h000;
`endif
      end else begin
        m.ls = 1'b0;
        m.fs = 1'b0;
      end
      m_e++;
    end else begin
      m.ls = 1'b0;
      m.fs = 1'b0;
    end
  endtask

  // Apply inputs for the next rising edge and queue what that edge must give.
  task automatic drive(input logic rst_v, input logic en_v, input int tag);
    @(negedge clk);
    reset = rst_v;
    en_i  = en_v;
    model_step(rst_v, en_v);
    m.tag = tag;
    q.push_back(m);
  endtask

  task automatic cmp(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s tag=%0d actual=%0h expected=%0h", nm, tag, act, req);
    end
  endtask

  // Monitor: pop one expectation per edge; also tally one frame after release.
  initial begin
    exp_t e;
    int von_cnt, hs_low, vs_low, ls_cnt, fs_cnt, last_ls;
    von_cnt = 0; hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0; last_ls = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("x_o", e.tag, 32'(x_o), 32'(e.x));
        cmp("y_o", e.tag, 32'(y_o), 32'(e.y));
        cmp("hsync", e.tag, 32'(hsync), 32'(e.hs));
        cmp("vsync", e.tag, 32'(vsync), 32'(e.vs));
        cmp("video_on", e.tag, 32'(video_on), 32'(e.von));
        cmp("line_start", e.tag, 32'(line_start_o), 32'(e.ls));
        cmp("frame_start", e.tag, 32'(frame_start_o), 32'(e.fs));
`ifdef VGA_TIMING_PAT_EN
        cmp("rgb_o", e.tag, 32'(rgb_dut), 32'(e.rgb));
`endif
        if (e.tag == 1) begin
          von_cnt = 0; hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0; last_ls = 0;
        end
        if (e.tag >= 1 && e.tag <= 225 && line_start_o) begin
          if (last_ls > 0) cmp("line_period", e.tag, 32'(e.tag - last_ls), 32'd28);
          last_ls = e.tag;
        end
        if (e.tag >= 1 && e.tag <= 224) begin
          von_cnt += int'(video_on);
          hs_low  += int'(!hsync);
          vs_low  += int'(!vsync);
          ls_cnt  += int'(line_start_o);
          fs_cnt  += int'(frame_start_o);
        end
        if (e.tag == 225) begin
          cmp("frame_restart", e.tag, 32'(frame_start_o), 32'd1);
          cmp("video_clks", e.tag, 32'(von_cnt), 32'd64);
          cmp("hsync_clks", e.tag, 32'(hs_low), 32'd48);
          cmp("vsync_clks", e.tag, 32'(vs_low), 32'd56);
          cmp("lines_per_frame", e.tag, 32'(ls_cnt), 32'd8);
          cmp("frames_per_frame", e.tag, 32'(fs_cnt), 32'd1);
        end
      end
    end
  end

  // Stimulus: reset, clean frame, random enable gaps, mid-frame reset, rerun.
  initial begin
    bit found;
    logic en_v;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, -1);
    for (int t = 1; t <= 230; t++) drive(1'b1, 1'b1, t);
    for (int i = 0; i < 700; i++) begin
      en_v = ($urandom_range(0, 9) != 0);
      if (i >= 300 && i < 310) en_v = 1'b0;
      drive(1'b1, en_v, -1);
    end
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      drive(1'b1, 1'b1, -1);
      found = (m.x == CW'(11)) && (m.y == CW'(5));
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_x11_y5 actual=not_reached expected=reached");
    end
    drive(1'b0, 1'b1, -1);
    for (int t = 1; t <= 230; t++) drive(1'b1, 1'b1, t);
    for (int i = 0; i < 300; i++) drive(1'b1, ($urandom_range(0, 3) != 0), -1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised video timing generator; successor to the fixed 640x480 sync block. Any mode is set by per-axis active/porch/sync parameters, the pixel-clock divide ratio and the sync polarities. All outputs are registered and mutually aligned. It adds line/frame strobes and a run enable, and sits between the system clock and the framebuffer/pixel pipeline.

Parameters:
CW, 12, width of x/y counters and outputs
PIX_DIV, 2, system clocks per pixel (>=1; 1 = tick every clock)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
V_SYNC_POL, 0, asserted level of vsync

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
en_i  in  1  run enable; low freezes divider, counters and outputs
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
x_o  out  CW  horizontal position, 0..H_TOTAL-1
y_o  out  CW  vertical position, 0..V_TOTAL-1
video_on  out  1  high when x_o<H_ACTIVE and y_o<V_ACTIVE
line_start_o  out  1  one-clk strobe when x_o loads 0
frame_start_o  out  1  one-clk strobe when x_o and y_o both load 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Elaboration error if H_TOTAL or V_TOTAL > 2^CW, if PIX_DIV<1, or if any region width is 0.
- Region order per axis: active, front porch, sync, back porch.
- hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync uses the same rule on v.
- Reset (reset==0 at clk edge): divider, h, v = 0; x_o = y_o = 0; video_on = 0; hsync = ~H_SYNC_POL; vsync = ~V_SYNC_POL; strobes = 0. Applies immediately mid-frame.
- Pixel tick: divider counts 0..PIX_DIV-1 while en_i=1. tick = en_i && div==0, so the first tick occurs on the first enabled clk after reset release.
- On tick: h wraps at H_TOTAL-1 to 0. v advances only when h==H_TOTAL-1 and wraps at V_TOTAL-1.
- Output registers load on tick from the current (h,v) decode. All outputs therefore lag the counters by exactly one tick and are aligned with each other; there is no combinational output.
- Between ticks all outputs hold.
- line_start_o = 1 for the single clk following a tick that loaded x_o=0, else 0. frame_start_o adds the condition y_o=0.
- en_i=0: divider, counters and outputs hold. Strobes drop to 0 after one clk and do not re-fire on resume.

Optional Feature:
VGA_TIMING_PAT_EN:
- Defined: adds output rgb_o [11:0] (4:4:4). Eight vertical colour bars in order white, yellow, cyan, green, magenta, red, blue, black.
- Bar index = floor(x_o*8/H_ACTIVE), implemented as an incremental bar counter cleared at line start, not a divider.
- rgb_o is registered alongside video_on and is 12'h000 whenever video_on=0. Reset value is 0.
- Undefined: port absent; no bar logic.

Decomposition:
- Package vga_timing_pkg: 640x480@60 default constants; the bar colour table; a function computing TOTAL from the four region widths.
- Sub-module vga_axis_counter: generic wrapping counter with inc and wrap-out. Instantiated twice (h chained to v).

Test Plan:
Use small mode CW=5, PIX_DIV=2, H=8/2/3/1 (H_TOTAL=14), V=4/1/2/1 (V_TOTAL=8), polarities 0. One frame = 224 clk.
1. Release reset, en_i=1. Required: frame_start_o pulses at clk 1 and clk 225. line_start_o period is 28 clk. x_o sequence is 0..13.
2. Sync windows. Required: hsync low exactly while x_o in 10..12, 6 clk per line. vsync low exactly while y_o in 5..6, 56 clk per frame.
3. Required: video_on high only for x_o<8 && y_o<4, giving 64 clk per frame.
4. Assert reset at x_o=11, y_o=5. Required: next clk x_o=y_o=0, hsync=vsync=1, video_on=0. Restart is identical to scenario 1.
5. Drop en_i for 10 clk mid-line. Required: outputs frozen, no extra strobes, and the frame period extends by exactly 10 clk.
6. PAT_EN with H_ACTIVE=8. Required: rgb_o steps through all 8 bar colours, one per visible x_o, and is 0 outside visible.
